// File: rtl/vga_timing_generator.sv
// VGA raster timing source: pixel/line counters, display enable, sync pulses
// delayed to match the colour path, and a per-frame vertical-blank tick/counter.

module vga_timing_generator_param_check #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 1
) ();
    generate
        if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
            V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
            SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_illegal_params
            $error("vga_timing_generator: illegal timing parameters");
        end
    endgenerate
endmodule

module vga_timing_generator #(
    parameter int H_VISIBLE       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int SYNC_DELAY      = 1
) (
    input  logic        vga_clock,
    input  logic        reset,
    output logic [31:0] column,
    output logic [31:0] row,
    output logic        display_enable,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vblank_tick,
    output logic [15:0] frame_count
);
    localparam logic [31:0] H_TOTAL  = 32'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [31:0] V_TOTAL  = 32'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [31:0] H_VIS    = 32'(H_VISIBLE);
    localparam logic [31:0] V_VIS    = 32'(V_VISIBLE);
    localparam logic [31:0] HS_FIRST = 32'(H_VISIBLE + H_FRONT);
    localparam logic [31:0] HS_LAST  = 32'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [31:0] VS_FIRST = 32'(V_VISIBLE + V_FRONT);
    localparam logic [31:0] VS_LAST  = 32'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic        SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic        SYNC_OFF = ~SYNC_ON;
    localparam int          PIPE_W   = SYNC_DELAY + 1;

    vga_timing_generator_param_check #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .SYNC_DELAY(SYNC_DELAY)
    ) u_param_check ();

    logic [31:0]       column_q, column_d;
    logic [31:0]       row_q, row_d;
    logic              display_enable_q, display_enable_d;
    logic              vblank_tick_q, vblank_tick_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic [PIPE_W-1:0] hsync_q, hsync_d;
    logic [PIPE_W-1:0] vsync_q, vsync_d;
    logic              hsync_raw, vsync_raw;

    // Next raster position; flags are derived from it so they land with the counters
    always_comb begin
        if (column_q == H_TOTAL - 32'd1) begin
            column_d = 32'd0;
            if (row_q == V_TOTAL - 32'd1) begin
                row_d = 32'd0;
            end else begin
                row_d = row_q + 32'd1;
            end
        end else begin
            column_d = column_q + 32'd1;
            row_d    = row_q;
        end

        display_enable_d = (column_d < H_VIS) && (row_d < V_VIS);
        vblank_tick_d    = (column_d == 32'd0) && (row_d == V_VIS);
        if (vblank_tick_d) begin
            frame_count_d = frame_count_q + 16'd1;
        end else begin
            frame_count_d = frame_count_q;
        end

        hsync_raw = (column_d >= HS_FIRST) && (column_d <= HS_LAST);
        vsync_raw = (row_d >= VS_FIRST) && (row_d <= VS_LAST);
        // Bit 0 is the newest stage, the MSB drives the pin
        hsync_d = PIPE_W'({hsync_q, (hsync_raw ? SYNC_ON : SYNC_OFF)});
        vsync_d = PIPE_W'({vsync_q, (vsync_raw ? SYNC_ON : SYNC_OFF)});
    end

    // State registers; reset parks the counters one pixel before (0,0)
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            column_q         <= H_TOTAL - 32'd1;
            row_q            <= V_TOTAL - 32'd1;
            display_enable_q <= 1'b0;
            vblank_tick_q    <= 1'b0;
            frame_count_q    <= 16'd0;
            hsync_q          <= {PIPE_W{SYNC_OFF}};
            vsync_q          <= {PIPE_W{SYNC_OFF}};
        end else begin
            column_q         <= column_d;
            row_q            <= row_d;
            display_enable_q <= display_enable_d;
            vblank_tick_q    <= vblank_tick_d;
            frame_count_q    <= frame_count_d;
            hsync_q          <= hsync_d;
            vsync_q          <= vsync_d;
        end
    end

    assign column         = column_q;
    assign row            = row_q;
    assign display_enable = display_enable_q;
    assign vblank_tick    = vblank_tick_q;
    assign frame_count    = frame_count_q;
    assign vga_hsync      = hsync_q[SYNC_DELAY];
    assign vga_vsync      = vsync_q[SYNC_DELAY];
endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: three configurations on one clock, each
// compared per cycle against an arithmetic raster model of elapsed cycles.

module tb_vga_timing_generator;
    typedef struct packed {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
        int act_low; int dly;
    } cfg_t;

    typedef struct packed {
        logic [31:0] col;
        logic [31:0] row;
        logic        de;
        logic        hs;
        logic        vs;
        logic        vb;
        logic [15:0] fc;
    } obs_t;

    localparam cfg_t C_DEF   = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, act_low:1, dly:0};
    localparam cfg_t C_MED   = '{hv:16, hf:2, hs:3, hb:2, vv:12, vf:2, vs:2, vb:3, act_low:1, dly:2};
    localparam cfg_t C_SMALL = '{hv:4, hf:1, hs:1, hb:1, vv:2, vf:1, vs:1, vb:1, act_low:0, dly:1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_def = 1'b1, rst_med = 1'b1, rst_small = 1'b1;
    logic [31:0] col_def, row_def, col_med, row_med, col_small, row_small;
    logic de_def, hs_def, vs_def, vb_def, de_med, hs_med, vs_med, vb_med;
    logic de_small, hs_small, vs_small, vb_small;
    logic [15:0] fc_def, fc_med, fc_small;

    vga_timing_generator #(.H_VISIBLE(C_DEF.hv), .H_FRONT(C_DEF.hf), .H_SYNC(C_DEF.hs), .H_BACK(C_DEF.hb),
        .V_VISIBLE(C_DEF.vv), .V_FRONT(C_DEF.vf), .V_SYNC(C_DEF.vs), .V_BACK(C_DEF.vb),
        .SYNC_ACTIVE_LOW(C_DEF.act_low), .SYNC_DELAY(C_DEF.dly)) u_def (
        .vga_clock(clk), .reset(rst_def), .column(col_def), .row(row_def), .display_enable(de_def),
        .vga_hsync(hs_def), .vga_vsync(vs_def), .vblank_tick(vb_def), .frame_count(fc_def));

    vga_timing_generator #(.H_VISIBLE(C_MED.hv), .H_FRONT(C_MED.hf), .H_SYNC(C_MED.hs), .H_BACK(C_MED.hb),
        .V_VISIBLE(C_MED.vv), .V_FRONT(C_MED.vf), .V_SYNC(C_MED.vs), .V_BACK(C_MED.vb),
        .SYNC_ACTIVE_LOW(C_MED.act_low), .SYNC_DELAY(C_MED.dly)) u_med (
        .vga_clock(clk), .reset(rst_med), .column(col_med), .row(row_med), .display_enable(de_med),
        .vga_hsync(hs_med), .vga_vsync(vs_med), .vblank_tick(vb_med), .frame_count(fc_med));

    vga_timing_generator #(.H_VISIBLE(C_SMALL.hv), .H_FRONT(C_SMALL.hf), .H_SYNC(C_SMALL.hs), .H_BACK(C_SMALL.hb),
        .V_VISIBLE(C_SMALL.vv), .V_FRONT(C_SMALL.vf), .V_SYNC(C_SMALL.vs), .V_BACK(C_SMALL.vb),
        .SYNC_ACTIVE_LOW(C_SMALL.act_low), .SYNC_DELAY(C_SMALL.dly)) u_small (
        .vga_clock(clk), .reset(rst_small), .column(col_small), .row(row_small), .display_enable(de_small),
        .vga_hsync(hs_small), .vga_vsync(vs_small), .vblank_tick(vb_small), .frame_count(fc_small));

    obs_t o_def, o_med, o_small;
    assign o_def   = {col_def, row_def, de_def, hs_def, vs_def, vb_def, fc_def};
    assign o_med   = {col_med, row_med, de_med, hs_med, vs_med, vb_med, fc_med};
    assign o_small = {col_small, row_small, de_small, hs_small, vs_small, vb_small, fc_small};

    // Cycles elapsed since reset release (-1 while reset is applied)
    int t_def = -1, t_med = -1, t_small = -1;
    always @(posedge clk) begin
        t_def   <= rst_def   ? -1 : t_def + 1;
        t_med   <= rst_med   ? -1 : t_med + 1;
        t_small <= rst_small ? -1 : t_small + 1;
    end

    int total = 0;
    int bad = 0;
    int fo_small = 0;

    function automatic int frames_done(cfg_t c, int t);
        int ht, vt;
        ht = c.hv + c.hf + c.hs + c.hb;
        vt = c.vv + c.vf + c.vs + c.vb;
        if (t < c.vv * ht) return 0;
        return (t - c.vv * ht) / (ht * vt) + 1;
    endfunction

    function automatic obs_t model(cfg_t c, int t, int fo);
        obs_t e;
        int ht, vt, cc, rr, td, cd, rd;
        logic on;
        ht = c.hv + c.hf + c.hs + c.hb;
        vt = c.vv + c.vf + c.vs + c.vb;
        on = (c.act_low != 0) ? 1'b0 : 1'b1;
        if (t < 0) begin
            e = '{col: 32'(ht - 1), row: 32'(vt - 1), de: 1'b0, hs: ~on, vs: ~on, vb: 1'b0, fc: 16'd0};
            return e;
        end
        cc = t % ht;
        rr = (t / ht) % vt;
        e.col = 32'(cc);
        e.row = 32'(rr);
        e.de  = (cc < c.hv) && (rr < c.vv);
        e.vb  = (cc == 0) && (rr == c.vv);
        e.fc  = 16'(frames_done(c, t) + fo);
        td = t - c.dly;
        if (td < 0) begin
            e.hs = ~on;
            e.vs = ~on;
        end else begin
            cd = td % ht;
            rd = (td / ht) % vt;
            e.hs = (cd >= c.hv + c.hf && cd < c.hv + c.hf + c.hs) ? on : ~on;
            e.vs = (rd >= c.vv + c.vf && rd < c.vv + c.vf + c.vs) ? on : ~on;
        end
        return e;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("col=%0d row=%0d de=%b hs=%b vs=%b vb=%b fc=%0d",
                         o.col, o.row, o.de, o.hs, o.vs, o.vb, o.fc);
    endfunction

    task automatic test_reset();
        obs_t e;
        rst_def = 1'b1; rst_med = 1'b1; rst_small = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = model(C_DEF, -1, 0);
            total++; if (o_def !== e) begin bad++; $display("FAIL reset_def got %s want %s", fmt(o_def), fmt(e)); end
            e = model(C_MED, -1, 0);
            total++; if (o_med !== e) begin bad++; $display("FAIL reset_med got %s want %s", fmt(o_med), fmt(e)); end
            e = model(C_SMALL, -1, 0);
            total++; if (o_small !== e) begin bad++; $display("FAIL reset_small got %s want %s", fmt(o_small), fmt(e)); end
        end
        rst_def = 1'b0; rst_med = 1'b0; rst_small = 1'b0;
        @(negedge clk);
        e = model(C_DEF, 0, 0);
        total++; if (o_def !== e) begin bad++; $display("FAIL release_def got %s want %s", fmt(o_def), fmt(e)); end
        e = model(C_MED, 0, 0);
        total++; if (o_med !== e) begin bad++; $display("FAIL release_med got %s want %s", fmt(o_med), fmt(e)); end
        e = model(C_SMALL, 0, 0);
        total++; if (o_small !== e) begin bad++; $display("FAIL release_small got %s want %s", fmt(o_small), fmt(e)); end
    endtask

    task automatic test_line_timing();
        obs_t e;
        int hs_cnt = 0, de_cnt = 0, first_hs = -1;
        for (int i = 0; i < 2400; i++) begin
            @(negedge clk);
            e = model(C_DEF, t_def, 0);
            total++; if (o_def !== e) begin bad++; $display("FAIL line_def t=%0d got %s want %s", t_def, fmt(o_def), fmt(e)); end
            if (t_def >= 800 && t_def < 1600) begin
                if (hs_def == 1'b0) begin
                    hs_cnt++;
                    if (first_hs < 0) first_hs = int'(col_def);
                end
                if (de_def) de_cnt++;
            end
        end
        total++; if (hs_cnt != 96) begin bad++; $display("FAIL hsync_width got %0d want 96", hs_cnt); end
        total++; if (first_hs != 656) begin bad++; $display("FAIL hsync_start got %0d want 656", first_hs); end
        total++; if (de_cnt != 640) begin bad++; $display("FAIL de_per_line got %0d want 640", de_cnt); end
    endtask

    task automatic test_frame_timing();
        obs_t e;
        int vb_cnt = 0, vs_cnt = 0, de_cnt = 0;
        for (int i = 0; i < 2 * 437; i++) begin
            @(negedge clk);
            e = model(C_MED, t_med, 0);
            total++; if (o_med !== e) begin bad++; $display("FAIL frame_med t=%0d got %s want %s", t_med, fmt(o_med), fmt(e)); end
            if (vb_med) vb_cnt++;
            if (vs_med == 1'b0) vs_cnt++;
            if (de_med) de_cnt++;
        end
        total++; if (vb_cnt != 2) begin bad++; $display("FAIL vblank_count got %0d want 2", vb_cnt); end
        total++; if (vs_cnt != 92) begin bad++; $display("FAIL vsync_cycles got %0d want 92", vs_cnt); end
        total++; if (de_cnt != 384) begin bad++; $display("FAIL de_cycles got %0d want 384", de_cnt); end
    endtask

    task automatic test_sync_delay();
        int n = 0;
        logic [2:0] hs_seen, vs_seen;
        do begin @(negedge clk); n++; end while (col_med !== 32'd18 && n < 500);
        total++; if (col_med !== 32'd18) begin bad++; $display("FAIL hsync_wait timeout col=%0d", col_med); end
        for (int k = 0; k < 3; k++) begin
            hs_seen[k] = hs_med;
            if (k < 2) @(negedge clk);
        end
        total++; if (hs_seen !== 3'b011) begin bad++; $display("FAIL hsync_delay2 got %b want 011", hs_seen); end
        n = 0;
        do begin @(negedge clk); n++; end while (!(row_med === 32'd14 && col_med === 32'd0) && n < 1000);
        total++; if (row_med !== 32'd14 || col_med !== 32'd0) begin bad++; $display("FAIL vsync_wait timeout row=%0d", row_med); end
        for (int k = 0; k < 3; k++) begin
            vs_seen[k] = vs_med;
            if (k < 2) @(negedge clk);
        end
        total++; if (vs_seen !== 3'b011) begin bad++; $display("FAIL vsync_delay2 got %b want 011", vs_seen); end
    endtask

    task automatic mid_reset_at(int pos, int min_t, string tag);
        obs_t e;
        do @(negedge clk); while (!((t_med % 437) == pos && t_med >= min_t));
        e = model(C_MED, t_med, 0);
        total++; if (o_med !== e) begin bad++; $display("FAIL %s_before got %s want %s", tag, fmt(o_med), fmt(e)); end
        rst_med = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = model(C_MED, -1, 0);
            total++; if (o_med !== e) begin bad++; $display("FAIL %s_held got %s want %s", tag, fmt(o_med), fmt(e)); end
        end
        rst_med = 1'b0;
        for (int i = 0; i < 450; i++) begin
            @(negedge clk);
            e = model(C_MED, t_med, 0);
            total++; if (o_med !== e) begin bad++; $display("FAIL %s_restart t=%0d got %s want %s", tag, t_med, fmt(o_med), fmt(e)); end
        end
    endtask

    task automatic test_mid_reset();
        mid_reset_at(5 * 23 + 14, 0, "midreset_hs_idle");
        mid_reset_at(14 * 23 + 20, 437, "midreset_hs_active");
    endtask

    task automatic test_frame_wrap();
        obs_t e;
        logic [15:0] seen[$];
        int hs_cnt = 0;
        logic [15:0] want [4] = '{16'd65534, 16'd65535, 16'd0, 16'd1};
        do @(negedge clk); while ((t_small % 35) != 10);
        force u_small.frame_count_q = 16'd65533;
        @(negedge clk);
        release u_small.frame_count_q;
        fo_small = 65533 - frames_done(C_SMALL, t_small);
        for (int i = 0; i < 4 * 35; i++) begin
            @(negedge clk);
            e = model(C_SMALL, t_small, fo_small);
            total++; if (o_small !== e) begin bad++; $display("FAIL wrap_small t=%0d got %s want %s", t_small, fmt(o_small), fmt(e)); end
            if (vb_small) seen.push_back(fc_small);
            if (hs_small) hs_cnt++;
        end
        total++; if (seen.size() != 4) begin bad++; $display("FAIL wrap_ticks got %0d want 4", seen.size()); end
        for (int k = 0; k < 4 && k < seen.size(); k++) begin
            total++; if (seen[k] !== want[k]) begin bad++; $display("FAIL wrap_seq[%0d] got %0d want %0d", k, seen[k], want[k]); end
        end
        total++; if (hs_cnt != 20) begin bad++; $display("FAIL small_hsync_high got %0d want 20", hs_cnt); end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_sync_delay();
        test_mid_reset();
        test_frame_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
